row_decoder: RTL and testbench
==============================

# row_decoder

Registered one-hot row (wordline) decoder for the SRAM macro. It converts a binary row address plus an enable into a one-hot `row_select` vector that drives the bit-cell array wordlines. At most one row is asserted at any time. It sits between the SRAM control/address register logic and the array wordline drivers.

## Interface
- `ADDR_WIDTH`, default 6: width of the row address.
- `NUM_ROWS`, default 64: number of wordlines. Legal range is 2 ≤ NUM_ROWS ≤ 2**ADDR_WIDTH. Elaboration fails otherwise.
- `clk`  input  1  system clock, rising-edge active.
- `rst_n`  input  1  asynchronous, active-low reset.
- `addr`  input  ADDR_WIDTH  binary row address, unsigned.
- `enable`  input  1  row access enable, active-high.
- `row_select`  output  NUM_ROWS  one-hot wordline select; bit i selects row i.

## Operation
- Next-state decode value:
  - If `enable`=1 and `addr` < NUM_ROWS, exactly bit `addr` is 1 and all other bits are 0.
  - Otherwise the value is all zeros.
- `addr` ≥ NUM_ROWS (possible only when NUM_ROWS < 2**ADDR_WIDTH) is out of range and yields all zeros. There is no wrap-around or aliasing.
- `addr` is ignored whenever `enable`=0.
- Invariant: `row_select` is never multi-hot, in any state, including immediately after reset.
- No X propagation. `row_select` is driven from flops only.

## Timing
- `row_select` is registered. `addr` and `enable` are sampled on the rising edge of `clk`, and the result appears on `row_select` after that edge. Latency is one cycle.
- Back-to-back addresses are supported at full rate. If the address changes every cycle, `row_select` switches directly from one row to the next in one cycle, with no intermediate zero cycle and no overlap.
- Reset value: `row_select` = all zeros.
- Asserting `rst_n`=0 clears `row_select` immediately, independent of `clk`. This applies even mid-access.
- On deassertion of `rst_n`, the first edge with `rst_n`=1 samples the inputs normally.
- Simultaneous `enable` deassertion and `addr` change: the output goes to zeros on the next edge.

## Configuration
- Macro: `ROW_DECODER_PREDECODE_EN`.
- Defined: two-level decode.
  - The address is split into a high field (ceil(ADDR_WIDTH/2) bits) and a low field (floor(ADDR_WIDTH/2) bits).
  - Each field is predecoded to one-hot by a `row_predecoder` instance.
  - Row i = hi_onehot[i >> low_bits] AND lo_onehot[i & low_mask], gated by enable and the range check. The result is registered.
- Undefined: flat compare decode, row i = (addr == i) gated by enable and the range check.
- Both variants are cycle-for-cycle identical at `row_select`. The same bench must pass on both.

## Structure
- Shared package `sram_pkg`:
  - `SRAM_ROW_ADDR_W` = 6.
  - `SRAM_NUM_ROWS` = 64.
  - typedef `row_addr_t` (logic [SRAM_ROW_ADDR_W-1:0]).
  - typedef `row_sel_t` (logic [SRAM_NUM_ROWS-1:0]).
  - These are the parameter defaults.
- Sub-module `row_predecoder` (parameter IN_WIDTH; input `in`, output 2**IN_WIDTH one-hot) is combinational and has no clock. It is instantiated only under `ROW_DECODER_PREDECODE_EN`.
- Include a simulation-only one-hot-or-zero assertion on `row_select`, checked every cycle while `rst_n`=1.

## Test plan
- Reset: drive `rst_n`=0 with `enable`=1, `addr`=5 → `row_select`=0 during reset. Release reset; the next edge gives `row_select`=64'h20.
- Sweep: `enable`=1, `addr`=0..63, one per cycle → each cycle `row_select` = 1<<addr of the previous cycle, and $countones=1.
- Disable: `enable`=0, `addr`=17 → `row_select`=0 after one edge. Re-enable → 1<<17 after one edge.
- Boundaries: `addr`=0 → 64'h1. `addr`=63 → 64'h8000_0000_0000_0000.
- Out of range: with NUM_ROWS=48 and `addr`=50 plus `enable`=1 → `row_select`=0. `addr`=47 → bit 47 only.
- Async reset mid-access: `row_select`=1<<9, then `rst_n` falls between edges → `row_select` reads 0 before the next `clk` edge.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM macro definitions: row address/select widths and the matching
// typedefs used as defaults by the row-path blocks.
package sram_pkg;

    localparam int SRAM_ROW_ADDR_W = 6;
    localparam int SRAM_NUM_ROWS   = 64;

    typedef logic [SRAM_ROW_ADDR_W-1:0] row_addr_t;
    typedef logic [SRAM_NUM_ROWS-1:0]   row_sel_t;

endpackage : sram_pkg

// File: rtl/row_predecoder.sv
// Combinational binary-to-one-hot predecoder for one address field of the
// two-level row decode.
module row_predecoder #(
    parameter int IN_WIDTH = 3
) (
    input  logic [IN_WIDTH-1:0]      in,
    output logic [2**IN_WIDTH-1:0]   out
);

    // NOTE: every always_comb output gets a default first; a path that skips
    // the assignment would otherwise infer a latch.
    always_comb begin
        out     = '0;
        out[in] = 1'b1;
    end

endmodule : row_predecoder

// File: rtl/row_decoder.sv
// Registered one-hot wordline decoder. Defining ROW_DECODER_PREDECODE_EN
// selects a two-level predecoded structure; otherwise a flat compare decode.
module row_decoder
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ROW_ADDR_W,
    parameter int NUM_ROWS   = SRAM_NUM_ROWS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  enable,
    output logic [NUM_ROWS-1:0]   row_select
);

    generate
        if (NUM_ROWS < 2 || NUM_ROWS > 2**ADDR_WIDTH) begin : g_bad_cfg
            $error("row_decoder: NUM_ROWS must lie in [2, 2**ADDR_WIDTH]");
        end
    endgenerate

    localparam logic [ADDR_WIDTH:0] ROW_LIMIT = (ADDR_WIDTH+1)'(NUM_ROWS);

    logic                in_range;
    logic [NUM_ROWS-1:0] row_match;
    logic [NUM_ROWS-1:0] row_next;

    // Out-of-range addresses select nothing rather than aliasing onto a row.
    assign in_range = {1'b0, addr} < ROW_LIMIT;

`ifdef ROW_DECODER_PREDECODE_EN
    localparam int LO_W = ADDR_WIDTH / 2;
    localparam int HI_W = ADDR_WIDTH - LO_W;

    logic [2**HI_W-1:0] hi_onehot;
    logic [2**LO_W-1:0] lo_onehot;
    logic               unused_hi;

    row_predecoder #(.IN_WIDTH(HI_W)) u_hi_predec (
        .in  (addr[ADDR_WIDTH-1:LO_W]),
        .out (hi_onehot)
    );

    generate
        if (LO_W > 0) begin : g_lo_field
            row_predecoder #(.IN_WIDTH(LO_W)) u_lo_predec (
                .in  (addr[LO_W-1:0]),
                .out (lo_onehot)
            );
        end else begin : g_no_lo_field
            assign lo_onehot = 1'b1;
        end

        for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
            assign row_match[i] = hi_onehot[i >> LO_W] & lo_onehot[i % (2**LO_W)];
        end
    endgenerate

    // Upper predecode outputs have no row when NUM_ROWS is not a power of two.
    assign unused_hi = ^hi_onehot;
`else
    generate
        for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
            assign row_match[i] = (addr == ADDR_WIDTH'(i));
        end
    endgenerate
`endif

    assign row_next = (enable && in_range) ? row_match : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_select <= '0;
        end else begin
            row_select <= row_next;
        end
    end

`ifndef SYNTHESIS
    a_row_select_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(row_select)
    ) else $error("row_decoder: row_select is multi-hot: %h", row_select);
`endif

endmodule : row_decoder

// File: tb/tb_row_decoder.sv
// Directed self-checking bench for row_decoder: reset, full sweep, enable
// gating, boundaries, out-of-range rows (48-row instance) and async reset.
module tb_row_decoder;

    logic        clk;
    logic        rst_n;
    logic [5:0]  addr;
    logic        enable;
    logic [63:0] row_select;
    logic [47:0] row_select_48;

    int n_checks;
    int n_fail;

    row_decoder #(.ADDR_WIDTH(6), .NUM_ROWS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .enable     (enable),
        .row_select (row_select)
    );

    row_decoder #(.ADDR_WIDTH(6), .NUM_ROWS(48)) dut48 (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .enable     (enable),
        .row_select (row_select_48)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_sel;
        n_checks = 0;
        n_fail   = 0;

        // Reset held with an active request pending.
        rst_n  = 1'b0;
        enable = 1'b1;
        addr   = 6'd5;
        step();
        step();
        check("reset_row_select", row_select, 64'h0);
        check("reset_row_select_48", {16'h0, row_select_48}, 64'h0);

        // First edge after release samples inputs normally.
        rst_n = 1'b1;
        step();
        check("post_reset_addr5", row_select, 64'h20);

        // Full-rate sweep: each row follows directly from the previous one.
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a);
            step();
            exp_sel = 64'd1 << a;
            check($sformatf("sweep_addr%0d", a), row_select, exp_sel);
            check($sformatf("sweep_ones%0d", a), 64'($countones(row_select)), 64'd1);
        end

        // Enable gating.
        enable = 1'b0;
        addr   = 6'd17;
        step();
        check("disable_addr17", row_select, 64'h0);
        enable = 1'b1;
        step();
        check("reenable_addr17", row_select, 64'h0000_0000_0002_0000);

        // Boundaries.
        addr = 6'd0;
        step();
        check("boundary_addr0", row_select, 64'h1);
        addr = 6'd63;
        step();
        check("boundary_addr63", row_select, 64'h8000_0000_0000_0000);
        check("oor48_addr63", {16'h0, row_select_48}, 64'h0);

        // Enable drop together with an address change.
        enable = 1'b0;
        addr   = 6'd3;
        step();
        check("disable_with_addr_change", row_select, 64'h0);

        // Out-of-range rows on the 48-row instance.
        enable = 1'b1;
        addr   = 6'd50;
        step();
        check("oor48_addr50", {16'h0, row_select_48}, 64'h0);
        check("full64_addr50", row_select, 64'h0004_0000_0000_0000);
        addr = 6'd47;
        step();
        check("oor48_addr47", {16'h0, row_select_48}, 64'h0000_8000_0000_0000);

        // Asynchronous reset between edges clears the output immediately.
        addr = 6'd9;
        step();
        check("pre_async_addr9", row_select, 64'h200);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", row_select, 64'h0);
        check("async_reset_clears_48", {16'h0, row_select_48}, 64'h0);
        step();
        rst_n  = 1'b1;
        enable = 1'b0;
        step();
        check("post_async_disabled", row_select, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_row_decoder
